// File: rtl/alu_pipe_param.sv
// alu_pipe_param: two-stage pipelined ALU, 16 opcodes, registered flags.
// Valid/ready on both sides; stage 1 = operand regs, stage 2 = result regs.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   input handshake (opcode, input1, input2, shiftValue)
//   out_valid / out_ready output handshake (result + flags)
//   result                WIDTH-bit registered result
//   carryFlag             carry / borrow / last bit shifted out
//   zeroFlag              result == 0
//   negativeFlag          result MSB
//   overflowFlag          signed overflow, ADD and SUB only
module alu_pipe_param #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             negativeFlag,
    output logic             overflowFlag
);

    localparam logic [3:0] OP_SGE  = 4'd0;
    localparam logic [3:0] OP_MAX  = 4'd1;
    localparam logic [3:0] OP_SGT  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_ROR  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MIN  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;
    localparam logic [3:0] OP_SLL  = 4'd14;
    localparam logic [3:0] OP_SRL  = 4'd15;

    // Stage 1 state
    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [SHW-1:0]   s1_sh_q;

    // Stage 2 state (the outputs)
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;

    // Handshake
    logic s2_load;
    logic in_xfer;
    logic s1_valid_d;

    assign s2_load    = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_load;
    assign in_xfer    = in_valid && in_ready;
    assign s1_valid_d = in_xfer || (s1_valid_q && !s2_load);

    // Datapath
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;
    logic [SHW-1:0]   sh_neg;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH:0]   sll_w;
    logic [WIDTH:0]   srl_w;
    logic [WIDTH:0]   sra_w;
    logic [WIDTH-1:0] ror_w;
    logic             slt;
    logic             sgt;
    logic             sltu;

    assign a  = s1_a_q;
    assign b  = s1_b_q;
    assign sh = s1_sh_q;

    assign sum_w = {1'b0, a} + {1'b0, b};
    assign dif_w = {1'b0, a} - {1'b0, b};

    // Extra bit below/above the operand catches the last bit shifted out;
    // a zero shift leaves the guard bit at 0, so carry is 0 for free.
    assign sll_w = {1'b0, a} << sh;
    assign srl_w = {a, 1'b0} >> sh;
    assign sra_w = $signed({a, 1'b0}) >>> sh;

    // WIDTH is a power of two, so (WIDTH - sh) mod WIDTH == -sh in SHW bits.
    assign sh_neg = -sh;
    assign ror_w  = (a >> sh) | (a << sh_neg);

    assign slt  = $signed(a) < $signed(b);
    assign sgt  = $signed(a) > $signed(b);
    assign sltu = a < b;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (s1_op_q)
            OP_SGE:  res_d = {{(WIDTH-1){1'b0}}, !slt};
            OP_MAX:  res_d = sltu ? b : a;
            OP_SGT:  res_d = {{(WIDTH-1){1'b0}}, sgt};
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt};
            OP_NAND: res_d = ~(a & b);
            OP_ROR: begin
                res_d   = ror_w;
                carry_d = srl_w[0];
            end
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, sltu};
            OP_SRA: begin
                res_d   = sra_w[WIDTH:1];
                carry_d = sra_w[0];
            end
            OP_MIN:  res_d = sltu ? a : b;
            OP_OR:   res_d = a | b;
            OP_ADD: begin
                res_d   = sum_w[WIDTH-1:0];
                carry_d = sum_w[WIDTH];
                ovf_d   = (a[WIDTH-1] == b[WIDTH-1])
                       && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = dif_w[WIDTH-1:0];
                carry_d = dif_w[WIDTH];
                ovf_d   = (a[WIDTH-1] != b[WIDTH-1])
                       && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_d = a & b;
            OP_XOR:  res_d = a ^ b;
            OP_SLL: begin
                res_d   = sll_w[WIDTH-1:0];
                carry_d = sll_w[WIDTH];
            end
            OP_SRL: begin
                res_d   = srl_w[WIDTH:1];
                carry_d = srl_w[0];
            end
        endcase
    end

    assign zero_d = (res_d == '0);
    assign neg_d  = res_d[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sh_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_xfer) begin
                s1_op_q <= opcode;
                s1_a_q  <= input1;
                s1_b_q  <= input2;
                s1_sh_q <= shiftValue;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= res_d;
                carry_q  <= carry_d;
                zero_q   <= zero_d;
                neg_q    <= neg_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign carryFlag    = carry_q;
    assign zeroFlag     = zero_q;
    assign negativeFlag = neg_q;
    assign overflowFlag = ovf_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: scoreboard bench for alu_pipe_param, WIDTH 32 and 8.
// Directed vectors with hand-computed results; monitors pop and compare.
module tb_alu_pipe_param;

    localparam logic [3:0] SGE = 4'd0, MAX = 4'd1, SGT = 4'd2, SLT = 4'd3;
    localparam logic [3:0] NAND = 4'd4, ROR = 4'd5, SLTU = 4'd6, SRA = 4'd7;
    localparam logic [3:0] MIN = 4'd8, OR = 4'd9, ADD = 4'd10, SUB = 4'd11;
    localparam logic [3:0] AND = 4'd12, XOR = 4'd13, SLL = 4'd14, SRL = 4'd15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=32 instance
    logic        iv32 = 0, ir32, ov32, or32 = 1;
    logic [3:0]  op32 = 0;
    logic [31:0] a32 = 0, b32 = 0, r32;
    logic [4:0]  sh32 = 0;
    logic        cf32, zf32, nf32, vf32;

    alu_pipe_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32),
        .opcode(op32), .input1(a32), .input2(b32), .shiftValue(sh32),
        .out_valid(ov32), .out_ready(or32),
        .result(r32), .carryFlag(cf32), .zeroFlag(zf32),
        .negativeFlag(nf32), .overflowFlag(vf32)
    );

    // WIDTH=8 instance
    logic       iv8 = 0, ir8, ov8, or8 = 1;
    logic [3:0] op8 = 0;
    logic [7:0] a8 = 0, b8 = 0, r8;
    logic [2:0] sh8 = 0;
    logic       cf8, zf8, nf8, vf8;

    alu_pipe_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .opcode(op8), .input1(a8), .input2(b8), .shiftValue(sh8),
        .out_valid(ov8), .out_ready(or8),
        .result(r8), .carryFlag(cf8), .zeroFlag(zf8),
        .negativeFlag(nf8), .overflowFlag(vf8)
    );

    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;   // {carry, zero, negative, overflow}
        string       nm;
        bit          lat;
        int          icyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on every output transfer
    always @(negedge clk) begin
        if (rst_n && ov32 && or32) begin
            if (q32.size() == 0) begin
                chk("w32 unexpected output", 64'(r32), 64'hDEAD);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk({e.nm, " result"}, 64'(r32), e.res);
                chk({e.nm, " flags"}, 64'({cf32, zf32, nf32, vf32}), 64'(e.fl));
                if (e.lat)
                    chk({e.nm, " latency"}, 64'(cyc - e.icyc), 64'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected output", 64'(r8), 64'hDEAD);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk({e.nm, " result"}, 64'(r8), e.res);
                chk({e.nm, " flags"}, 64'({cf8, zf8, nf8, vf8}), 64'(e.fl));
            end
        end
    end

    // Callers enter just after a rising edge; returns just after the
    // rising edge on which the op was accepted.
    task automatic send32(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] r,
                          input logic [3:0] fl, input bit lat);
        int n;
        exp_t e;
        n = 0;
        iv32 = 1; op32 = op; a32 = a; b32 = b; sh32 = sh;
        @(negedge clk);
        while (!ir32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir32) begin
            chk({nm, " in_ready timeout"}, 64'(ir32), 64'd1);
        end else begin
            e.res = 64'(r); e.fl = fl; e.nm = nm; e.lat = lat; e.icyc = cyc;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        iv32 = 0;
    endtask

    task automatic send8(input string nm, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sh, input logic [7:0] r,
                         input logic [3:0] fl);
        int n;
        exp_t e;
        n = 0;
        iv8 = 1; op8 = op; a8 = a; b8 = b; sh8 = sh;
        @(negedge clk);
        while (!ir8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir8) begin
            chk({nm, " in_ready timeout"}, 64'(ir8), 64'd1);
        end else begin
            e.res = 64'(r); e.fl = fl; e.nm = nm; e.lat = 0; e.icyc = cyc;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        iv8 = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", 64'(q32.size() + q8.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nine;
        nine = 4'd9;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(ov32), 64'd0);
        chk("reset in_ready", 64'(ir32), 64'd1);
        chk("reset result", 64'(r32), 64'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Main function, back to back with out_ready high
        send32("ADD wrap", ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 4'b1100, 1);
        send32("ADD ovf", ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 4'b0011, 0);
        send32("SLT", SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 4'b0000, 0);
        send32("SLTU", SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 4'b0100, 0);
        send32("SGE eq", SGE, 32'd5, 32'd5, 5'd0, 32'h1, 4'b0000, 0);
        send32("SGT eq", SGT, 32'd5, 32'd5, 5'd0, 32'h0, 4'b0100, 0);
        send32("MAX", MAX, 32'h80000000, 32'h1, 5'd0, 32'h80000000, 4'b0010, 0);
        send32("MIN", MIN, 32'h80000000, 32'h1, 5'd0, 32'h1, 4'b0000, 0);
        send32("ROR 1", ROR, 32'h1, 32'h0, 5'd1, 32'h80000000, 4'b1010, 0);
        send32("SRA 4", SRA, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 4'b0010, 0);
        send32("SLL 1", SLL, 32'h80000001, 32'h0, 5'd1, 32'h2, 4'b1000, 0);
        send32("SRL 0", SRL, 32'h12345678, 32'h0, 5'd0, 32'h12345678, 4'b0000, 0);
        send32("SUB borrow", SUB, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 4'b1010, 0);
        send32("SUB ovf", SUB, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 4'b0001, 0);
        send32("NAND", NAND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FFF0FFF, 4'b0000, 0);
        send32("OR", OR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 4'b0010, 0);
        send32("AND", AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 4'b0010, 0);
        send32("XOR", XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 4'b0000, 0);
        send32("SRL 31", SRL, 32'hC0000000, 32'h0, 5'd31, 32'h1, 4'b1000, 0);
        drain();

        // Backpressure: stall 5 cycles, then release
        or32 = 0;
        fork
            begin
                send32("BP op1", ADD, 32'd1, 32'd1, 5'd0, 32'd2, 4'b0000, 0);
                send32("BP op2", ADD, 32'd2, 32'd2, 5'd0, 32'd4, 4'b0000, 0);
                send32("BP op3", ADD, 32'd3, 32'd3, 5'd0, 32'd6, 4'b0000, 0);
                send32("BP op4", ADD, 32'd4, 32'd4, 5'd0, 32'd8, 4'b0000, 0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i >= 2) begin
                        chk("BP in_ready low", 64'(ir32), 64'd0);
                        chk("BP out_valid held", 64'(ov32), 64'd1);
                        chk("BP result held", 64'(r32), 64'd2);
                    end
                end
                @(posedge clk);
                #1;
                or32 = 1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("BP consecutive out_valid", 64'(ov32), 64'd1);
                end
            end
        join
        drain();

        // Reset mid-stream with two ops in flight
        or32 = 0;
        send32("RST op1", XOR, 32'h1, 32'h2, 5'd0, 32'h3, 4'b0000, 0);
        send32("RST op2", XOR, 32'h4, 32'h8, 5'd0, 32'hC, 4'b0000, 0);
        chk("pre-reset in_ready", 64'(ir32), 64'd0);
        #3;
        rst_n = 0;
        #1;
        q32.delete();
        chk("mid reset out_valid", 64'(ov32), 64'd0);
        chk("mid reset result", 64'(r32), 64'd0);
        chk("mid reset flags", 64'({cf32, zf32, nf32, vf32}), 64'd0);
        chk("mid reset in_ready", 64'(ir32), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
        or32 = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset no output", 64'(ov32), 64'd0);
        end
        @(posedge clk);
        #1;
        send32("post reset ADD", ADD, 32'd10, 32'd20, 5'd0, 32'd30, 4'b0000, 1);
        drain();

        // WIDTH=8 instance
        send8("W8 SUB", SUB, 8'h00, 8'h01, 3'd0, 8'hFF, 4'b1010);
        send8("W8 ROR 9", ROR, 8'h01, 8'h00, nine[2:0], 8'h80, 4'b1010);
        send8("W8 ADD ovf", ADD, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0011);
        send8("W8 SLL 7", SLL, 8'h03, 8'h00, 3'd7, 8'h80, 4'b1010);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised, two-stage pipelined successor to the generated combinational ALUs. Operand width is generic.
- Implements all 16 opcodes, including the comparison ops, with no unimplemented cases.
- Produces registered carry, zero, negative and overflow flags.
- Uses valid/ready handshakes on input and output so it can sit between a decode stage and a writeback/scoreboard stage with backpressure.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values 8..64.
- SHW, $clog2(WIDTH), width of shiftValue; derived, not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  opcode/operands valid this cycle.
- in_ready  output  1  stage 1 can accept.
- opcode  input  4  operation select.
- input1  input  WIDTH  operand A.
- input2  input  WIDTH  operand B.
- shiftValue  input  SHW  shift/rotate amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts.
- result  output  WIDTH  registered result.
- carryFlag  output  1  registered carry/borrow/shift-out.
- zeroFlag  output  1  result == 0.
- negativeFlag  output  1  result[WIDTH-1].
- overflowFlag  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset: rst_n low asynchronously clears s1_valid, out_valid, result, all flags and stage-1 registers to 0. in_ready reads 1 while in reset (s1 empty).
- Reset mid-operation discards in-flight ops; nothing is emitted after reset release until a new transfer is made.
- Handshake:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - s2_load = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_load (combinational; no in_valid→in_ready path).
- Stage 1 registers opcode, input1, input2, shiftValue on an input transfer. s1_valid is set on transfer; it is cleared when s1 moves to s2 with no new input.
- Stage 2 computes from the s1 registers and registers result+flags when s1_valid & s2_load. out_valid follows s1_valid on that edge. out_valid clears on an output transfer with s1 empty.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 op/cycle with out_ready held high.
- Output stability: while out_valid & !out_ready, result and flags hold. Stage 1 holds one op, so a full pipe holds 2 ops and in_ready=0.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts the new op, advances s1, and retires s2 in one cycle.
- Opcodes:
  - 0 SGE (signed A>=B)
  - 1 MAX (unsigned)
  - 2 SGT (signed)
  - 3 SLT (signed)
  - 4 NAND
  - 5 ROR
  - 6 SLTU
  - 7 SRA
  - 8 MIN (unsigned)
  - 9 OR
  - 10 ADD
  - 11 SUB
  - 12 AND
  - 13 XOR
  - 14 SLL
  - 15 SRL
- Compare ops (0,2,3,6) return {WIDTH-1 zeros, bit}.
- Shifts/rotates use shiftValue modulo WIDTH, via the SHW-bit field. WIDTH that is not a power of two is unsupported.
- carryFlag:
  - ADD: carry-out of the WIDTH+1-bit sum.
  - SUB: borrow (1 when A<B unsigned).
  - SLL: last bit shifted out, input1[WIDTH-shiftValue].
  - SRL/SRA/ROR: input1[shiftValue-1].
  - Any shift/rotate with shiftValue=0: 0.
  - All other ops: 0.
- overflowFlag:
  - ADD: A,B same sign and result sign differs.
  - SUB: A,B signs differ and result sign differs from A.
  - Otherwise 0.
- zeroFlag and negativeFlag are evaluated for every opcode from the computed result.

Test Plan:
- Reset mid-stream: 2 ops in flight, pulse rst_n low between edges → out_valid=0, result=0, flags=0 immediately; in_ready=1; no output after release until new input.
- WIDTH=32, out_ready=1: ADD 0xFFFFFFFF+0x1 → result 0, carry=1, zero=1, overflow=0, out_valid exactly 2 cycles after transfer. ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1, negative=1.
- Compares: SLT 0xFFFFFFFF,0x1 → 1; SLTU same operands → 0; SGE 5,5 → 1; SGT 5,5 → 0. MAX/MIN 0x80000000,0x1 → 0x80000000 / 0x1.
- Shifts: ROR 0x00000001 by 1 → 0x80000000, carry=1; SRA 0x80000000 by 4 → 0xF8000000; SLL 0x80000001 by 1 → 0x00000002, carry=1; SRL by 0 → unchanged, carry=0.
- Backpressure: 4 back-to-back ops with out_ready=0 for 5 cycles → in_ready drops after 2 accepted; result holds op1 stable. Releasing out_ready → ops 1..4 emitted in order on consecutive cycles, none lost or duplicated.
- WIDTH=8 instance: SUB 0x00-0x01 → 0xFF, carry=1, negative=1; ROR 0x01 by 9 → behaves as shift 1 → 0x80.
